mat_key_emu: RTL and testbench
==============================

// Module: mat_key_emu
// PURPOSE
//  Emulates the 4x4 matrix keypad (responder end of the row-scan / column-sense interface).
//  - Watches the row strobes driven by the keypad scanner.
//  - Drives the column lines as if one requested key were physically held.
//  - Used for board self-test and simulation in place of the real keypad.
//  - Key index k = row*4 + col, matching the 16-bit btn[] map.
// PARAMETERS
//  RELEASE_FRAMES  4   scan frames with no key pressed after each press, before the next request is accepted
//  BOUNCE_FRAMES   2   frames of chatter at press and release (only with KEY_BOUNCE_EN)
//  SYNC_STAGES     2   synchroniser depth on row inputs (>=2)
// PORTS
//  clk        in   1  system clock (100 MHz)
//  rst        in   1  asynchronous, active-low reset
//  row        in   4  row strobes from scanner; active-low, one row low at a time
//  col        out  4  column sense to scanner; active-low
//  req_valid  in   1  press request valid
//  req_ready  out  1  emulator idle and able to accept a request
//  req_key    in   4  key index 0..15 to press
//  req_hold   in   8  press duration in complete scan frames; 0 is treated as 1
//  busy       out  1  high from request accept until the release gap ends
//  done       out  1  one-clk pulse when the release gap completes
// BEHAVIOUR
//  Reset values: col=4'hF, req_ready=1, busy=0, done=0, FSM=IDLE, all counters 0.
//  Row input path:
//   - row passes through a SYNC_STAGES flop chain, giving row_s.
//   - col is registered, so col reflects row_s one clk later.
//   - Total row-change-to-col latency is SYNC_STAGES+1 clk (3 by default).
//  Frame tick:
//   - A frame boundary is the clk on which row_s[0] goes 1->0.
//   - Partial frames are never counted.
//  Handshake:
//   - A request is accepted on a clk where req_valid & req_ready are both high.
//   - req_key and req_hold are latched on that clk.
//   - req_ready drops on the next clk.
//  FSM states:
//   - IDLE:    req_ready=1, col=F. Accept -> ARM.
//   - ARM:     col=F. Waits for the next frame tick, so a press never starts mid-frame. Then -> PRESS.
//   - PRESS:
//     - When row_s[key[3:2]]==0 and row_s has exactly one zero, col[key[1:0]]=0; otherwise col=F.
//     - Counts frame ticks. After hold frames (min 1) -> GAP.
//   - GAP:     col=F. Counts RELEASE_FRAMES frame ticks, then -> IDLE with done=1 for one clk.
//  Boundary conditions:
//   - row all-ones or multi-low: col=F in every state (ghost-safe).
//   - req_valid held while busy: ignored and not queued. Caller keeps it asserted until ready.
//   - Frame counter is 8 bits and saturates. hold=255 gives exactly 255 frames.
//   - Scanner stops scanning during PRESS: FSM stays in PRESS (no timeout).
//     col still follows row_s immediately when scanning restarts.
//   - Reset mid-press: col=F asynchronously and immediately; the request is lost.
// CONFIGURATION
//  KEY_BOUNCE_EN defined:
//   - During the first BOUNCE_FRAMES frames of PRESS and the first BOUNCE_FRAMES frames of GAP,
//     the pressed column is gated by bit 0 of a 16-bit LFSR (x^16+x^14+x^13+x^11+1).
//   - The LFSR advances every clk and is seeded to 16'hACE1 at reset.
//   - When the gate is 1 the column reads as pressed, producing chatter.
//   - Total PRESS length stays hold frames; bounce frames are counted within it.
//  KEY_BOUNCE_EN undefined: clean press/release. LFSR logic is not compiled in.
// STRUCTURE
//  Shared package (keypad_pkg):
//   - Key index constants: KEY_UP=2, KEY_RIGHT=5, KEY_DOWN=6, KEY_LEFT=7, KEY_OK=10, KEY_NUM=11,
//     KEY_EXIT=12, KEY_BACK=13, KEY_START=14, KEY_HELP=15.
//   - FSM state encoding emu_state_t {IDLE, ARM, PRESS, GAP}.
//   - Row/col width constant KP_N=4.
//  Sub-module: kp_row_sync, the SYNC_STAGES-deep synchroniser plus frame-tick detector.
//   - Reused later by any other row-scan consumer.
// TESTING (bench pairs this block with the real mat_key scanner, scan_clk = clk/5000)
//  1. Reset low for 10 clk: col=F, req_ready=1, busy=0. Row toggling during reset gives col=F.
//  2. Request key=14, hold=3:
//     - ARM waits for a frame tick.
//     - col[2]=0 only while row[3] is low, for exactly 3 frames.
//     - Scanner btn[14] asserts; done pulses after 3+4 frames.
//  3. Request key=0, hold=0: behaves as hold=1, giving exactly one frame with col[0] low during row[0].
//  4. Force row=4'b0101 (two rows low) during PRESS of key=5: col=F, then recovers when single-row scan resumes.
//  5. req_valid held high through a whole request:
//     - The second request is accepted only on the clk after done.
//     - busy stays 0 for exactly 1 clk between the two requests.
//  6. Drop rst mid-PRESS of key=10: col returns to F within the same clk. After release, req_ready=1.
//     With KEY_BOUNCE_EN, key=10 hold=6 shows >=1 col toggle in frames 1-2 and a stable press in frames 3-6.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix width, named key indices, emulator FSM encoding.
package keypad_pkg;

   localparam int unsigned KP_N = 4;

   localparam logic [3:0] KEY_UP    = 4'd2;
   localparam logic [3:0] KEY_RIGHT = 4'd5;
   localparam logic [3:0] KEY_DOWN  = 4'd6;
   localparam logic [3:0] KEY_LEFT  = 4'd7;
   localparam logic [3:0] KEY_OK    = 4'd10;
   localparam logic [3:0] KEY_NUM   = 4'd11;
   localparam logic [3:0] KEY_EXIT  = 4'd12;
   localparam logic [3:0] KEY_BACK  = 4'd13;
   localparam logic [3:0] KEY_START = 4'd14;
   localparam logic [3:0] KEY_HELP  = 4'd15;

   typedef enum logic [1:0] {IDLE, ARM, PRESS, GAP} emu_state_t;

   // True when exactly one row strobe is low (no idle bus, no ghosting pattern).
   function automatic logic one_low(input logic [KP_N-1:0] r);
      logic [KP_N-1:0] z;
      z = ~r;
      return (z != '0) && ((z & (z - KP_N'(1))) == '0);
   endfunction

endpackage

// File: rtl/kp_row_sync.sv
// Row strobe synchroniser plus frame-boundary detector (row_s[0] falling edge).
module kp_row_sync
   import keypad_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [KP_N-1:0] row,
   output logic [KP_N-1:0] row_s,
   output logic            frame_tick_c
);

   logic [KP_N-1:0] sync_q [SYNC_STAGES];
   logic [KP_N-1:0] sync_d [SYNC_STAGES];
   logic            prev_q, prev_d;

   // Shift chain feeding and last-value tracking for edge detection.
   always_comb begin
      sync_d[0] = row;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      prev_d = sync_q[SYNC_STAGES-1][0];
   end

   // Rows idle high, so reset the chain to all ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '1;
         end
         prev_q <= 1'b1;
      end else begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         prev_q <= prev_d;
      end
   end

   assign row_s        = sync_q[SYNC_STAGES-1];
   assign frame_tick_c = prev_q & ~row_s[0];

endmodule

// File: rtl/mat_key_emu.sv
// 4x4 matrix keypad emulator: answers row strobes with the column of one requested key.
// Optional contact chatter at press/release is compiled in with KEY_BOUNCE_EN.
module mat_key_emu
   import keypad_pkg::*;
#(
   parameter int unsigned RELEASE_FRAMES = 4,
   parameter int unsigned BOUNCE_FRAMES  = 2,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [KP_N-1:0] row,
   output logic [KP_N-1:0] col,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_key,
   input  logic [7:0]      req_hold,
   output logic            busy,
   output logic            done
);

   localparam int unsigned CNT_W = 8;

   logic [KP_N-1:0]  row_s;
   logic             frame_tick_c;
   emu_state_t       state_q, state_d;
   logic [3:0]       key_q, key_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [KP_N-1:0]  col_q, col_d;
   logic             req_ready_q, req_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             chat_c, in_bounce, press_on;

   kp_row_sync #(.SYNC_STAGES(SYNC_STAGES)) u_row_sync (
      .clk          (clk),
      .rst          (rst),
      .row          (row),
      .row_s        (row_s),
      .frame_tick_c (frame_tick_c)
   );

`ifdef KEY_BOUNCE_EN
   localparam bit BOUNCE_ON = 1'b1;
   logic [15:0] lfsr_q, lfsr_d;

   // Free-running x^16+x^14+x^13+x^11+1 LFSR supplying the chatter pattern.
   always_comb begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   end

   // LFSR register, seeded at reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr_q <= 16'hACE1;
      else      lfsr_q <= lfsr_d;
   end

   assign chat_c = lfsr_q[0];
`else
   localparam bit BOUNCE_ON = 1'b0;
   assign chat_c = 1'b1;
`endif

   // Next-state, frame counting and column response.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      col_d   = '1;
      cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               key_d   = req_key;
               hold_d  = (req_hold == 8'd0) ? 8'd1 : req_hold;
               cnt_d   = '0;
               state_d = ARM;
            end
         end
         ARM: begin
            if (frame_tick_c) begin
               cnt_d   = '0;
               state_d = PRESS;
            end
         end
         PRESS: begin
            if (frame_tick_c) begin
               if (cnt_inc >= hold_q) begin
                  cnt_d   = '0;
                  state_d = GAP;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         GAP: begin
            if (frame_tick_c) begin
               if (cnt_inc >= CNT_W'(RELEASE_FRAMES)) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Decide from the next state so the press aligns exactly with frame boundaries.
      in_bounce = cnt_d < CNT_W'(BOUNCE_FRAMES);
      press_on  = ((state_d == PRESS) && (!in_bounce || chat_c)) ||
                  ((state_d == GAP) && in_bounce && chat_c && BOUNCE_ON);
      if (press_on && one_low(row_s) && !row_s[key_q[3:2]]) begin
         col_d[key_q[1:0]] = 1'b0;
      end

      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         key_q       <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         col_q       <= '1;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign col       = col_q;
   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mat_key_emu.sv
// Directed bench for mat_key_emu with a simple row scanner (8 clk per row, 32 clk per frame).
module tb_mat_key_emu;
   import keypad_pkg::*;

   localparam int ROW_CLK = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_key;
   logic [7:0] req_hold;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   bit         scan_en = 1'b0;
   logic [3:0] row_idle = 4'hF;
   bit         mon_clr = 1'b0;
   logic [3:0] exp_col = 4'hF;
   int cyc = 0, n_match = 0, n_other = 0, n_done = 0;
   int last_match = 0, done_cyc = 0, low_run = 0, last_low = 0;

   mat_key_emu dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_key   (req_key),
      .req_hold  (req_hold),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Scanner model: one row low at a time, row 0 first.
   initial begin
      row = 4'hF;
      forever begin
         if (scan_en) begin
            for (int r = 0; r < 4; r++) begin
               row = 4'(~(4'b0001 << r));
               repeat (ROW_CLK) @(posedge clk);
               #1;
            end
         end else begin
            row = row_idle;
            @(posedge clk);
            #1;
         end
      end
   end

   // Monitor: column-pattern histogram, done pulses and busy-low run lengths.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mon_clr) begin
         n_match = 0; n_other = 0; n_done = 0; last_match = 0;
         done_cyc = 0; low_run = 0; last_low = 0;
      end else begin
         if (col === exp_col) begin
            n_match = n_match + 1;
            last_match = cyc;
         end else if (col !== 4'hF) begin
            n_other = n_other + 1;
         end
         if (done === 1'b1) begin
            n_done = n_done + 1;
            done_cyc = cyc;
         end
         if (busy === 1'b0) low_run = low_run + 1;
         else begin
            if (low_run > 0) last_low = low_run;
            low_run = 0;
         end
      end
   end

   task automatic clear_mon(input logic [3:0] e);
      exp_col = e;
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic request(input logic [3:0] k, input logic [7:0] h);
      bit acc;
      acc = 1'b0;
      @(negedge clk);
      req_key = k; req_hold = h; req_valid = 1'b1;
      for (int i = 0; i < 5000 && !acc; i++) begin
         if (req_ready === 1'b1) acc = 1'b1;
         @(posedge clk);
         #1;
         if (!acc) @(negedge clk);
      end
      req_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept key=%0d: req_ready never seen", k);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL post_accept: ready=%b busy=%b, required ready=0 busy=1", req_ready, busy);
      end
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout: no done in %0d clk", budget);
      end
   endtask

   task automatic wait_col(input logic [3:0] v, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (col === v) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 1'b0; req_key = 4'd0; req_hold = 8'd0;
      scan_en = 1'b1;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (col !== 4'hF || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: col=%h ready=%b busy=%b done=%b, required F 1 0 0",
                     col, req_ready, busy, done);
         end
      end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_key14_hold3();
      clear_mon(4'b1011);
      request(4'd14, 8'd3);
      wait_done(2000);
      @(negedge clk);
      checks++;
      if (n_match != 24) begin
         errors++; $display("FAIL k14_press_clk: got %0d, required 24", n_match);
      end
      checks++;
      if (n_other != 0) begin
         errors++; $display("FAIL k14_stray_col: got %0d, required 0", n_other);
      end
      checks++;
      if (done_cyc - last_match != 129) begin
         errors++; $display("FAIL k14_gap_len: got %0d, required 129", done_cyc - last_match);
      end
      checks++;
      if (n_done != 1 || done !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL k14_done_pulse: n=%0d done=%b ready=%b, required 1 0 1", n_done, done, req_ready);
      end
   endtask

   task automatic test_hold_zero();
      clear_mon(4'b1110);
      request(4'd0, 8'd0);
      wait_done(2000);
      @(negedge clk);
      checks++;
      if (n_match != 8 || n_other != 0) begin
         errors++;
         $display("FAIL hold0: press_clk=%0d stray=%0d, required 8 0", n_match, n_other);
      end
   endtask

   task automatic test_ghost();
      bit ok;
      clear_mon(4'b1101);
      request(4'd5, 8'd20);
      wait_col(4'b1101, 300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ghost_pre: col=%h, required D", col); end
      row_idle = 4'b0101;
      scan_en = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (col !== 4'hF) begin errors++; $display("FAIL ghost_col: col=%h, required F", col); end
      end
      row_idle = 4'hF;
      repeat (100) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || col !== 4'hF) begin
         errors++; $display("FAIL scan_stop: busy=%b col=%h, required 1 F", busy, col);
      end
      scan_en = 1'b1;
      wait_col(4'b1101, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ghost_recover: col=%h, required D", col); end
      wait_done(3000);
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_mon(4'b1011);
      @(negedge clk);
      req_key = 4'd2; req_hold = 8'd1; req_valid = 1'b1;
      wait_done(2000);
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_at_done: ready=%b busy=%b, required 1 0", req_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_second_accept: busy=%b ready=%b, required 1 0", busy, req_ready);
      end
      req_valid = 1'b0;
      wait_done(2000);
      @(negedge clk);
      checks++;
      if (last_low != 1) begin
         errors++; $display("FAIL b2b_busy_gap: got %0d clk, required 1", last_low);
      end
      checks++;
      if (n_match != 16 || n_done != 2) begin
         errors++; $display("FAIL b2b_counts: press_clk=%0d done=%0d, required 16 2", n_match, n_done);
      end
      ok = 1'b1;
   endtask

   task automatic test_reset_mid_press();
      bit ok;
      clear_mon(4'b1011);
      request(4'd10, 8'd6);
      wait_col(4'b1011, 300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL k10_press: col=%h, required B", col); end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (col !== 4'hF || busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: col=%h busy=%b ready=%b, required F 0 1", col, busy, req_ready);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      clear_mon(4'b1011);
      repeat (300) @(negedge clk);
      checks++;
      if (n_match != 0 || n_other != 0 || busy !== 1'b0 || req_ready !== 1'b1 || n_done != 0) begin
         errors++;
         $display("FAIL lost_request: press=%0d stray=%0d busy=%b ready=%b done=%0d, required 0 0 0 1 0",
                  n_match, n_other, busy, req_ready, n_done);
      end
   endtask

   initial begin
      test_reset();
      test_key14_hold3();
      test_hold_zero();
      test_ghost();
      test_back_to_back();
      test_reset_mid_press();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
